// File: rtl/serv_dbg_fetch.sv
// serv_dbg_fetch: latches fetched instructions, injects ebreak on debug entry, tracks RUN/PROCESS/DELAY, cause and PC-match triggers.
module serv_dbg_fetch #(
  parameter int NUM_TRIG   = 2,
  parameter int TRIG_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_wb_rdt,
  input  logic                  i_wb_en,
  input  logic [31:0]           i_pc,
  input  logic                  i_cnt_done,
  input  logic                  i_dret,
  input  logic                  i_dbg_halt,
  input  logic                  i_dbg_step,
  input  logic                  i_trig_wen,
  input  logic [TRIG_IDX_W-1:0] i_trig_idx,
  input  logic [31:0]           i_trig_addr,
  input  logic                  i_trig_ena,
  output logic [31:0]           o_instr,
  output logic                  o_dbg_process,
  output logic                  o_dbg_delay,
  output logic [2:0]            o_dbg_cause,
  output logic [NUM_TRIG-1:0]   o_trig_hit
);
  localparam logic [31:0] EBREAK  = 32'h00100073;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [1:0]  RUN     = 2'd0;
  localparam logic [1:0]  PROCESS = 2'd1;
  localparam logic [1:0]  DELAY   = 2'd2;
  logic [1:0]          state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [2:0]          cause_q, cause_d;
  logic [NUM_TRIG-1:0] trig_hit_q, trig_hit_d, ena_q, ena_d, hit;
  logic [31:0]         addr_q [NUM_TRIG];
  logic [31:0]         addr_d [NUM_TRIG];
  logic                run, req, enter;
  assign run   = state_q == RUN;
  assign req   = |hit | i_dbg_halt | i_dbg_step;
  assign enter = run & i_wb_en & (req | (i_wb_rdt == EBREAK));
  always_comb begin
    hit    = '0;
    ena_d  = ena_q;
    addr_d = addr_q;
    for (int k = 0; k < NUM_TRIG; k++) begin
      hit[k] = ena_q[k] & (addr_q[k] == i_pc);
      if (i_trig_wen && i_trig_idx == TRIG_IDX_W'(k)) begin
        ena_d[k]  = i_trig_ena;
        addr_d[k] = i_trig_addr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (i_rst) state_q <= DELAY;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = run ? (enter ? PROCESS : RUN) :
              state_q == PROCESS ? ((i_dret & i_cnt_done) ? DELAY : PROCESS) :
              (i_cnt_done ? RUN : DELAY);
  end
  always_comb begin
    instr_d    = i_wb_en ? ((run & req) ? EBREAK : i_wb_rdt) : instr_q;
    cause_d    = enter ? (|hit ? 3'd2 : i_dbg_halt ? 3'd3 : i_dbg_step ? 3'd4 : 3'd1) : cause_q;
    trig_hit_d = enter ? (|hit ? hit : '0) : trig_hit_q;
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      instr_q    <= NOP;
      cause_q    <= '0;
      trig_hit_q <= '0;
      ena_q      <= '0;
      addr_q     <= '{default: '0};
    end else begin
      instr_q    <= instr_d;
      cause_q    <= cause_d;
      trig_hit_q <= trig_hit_d;
      ena_q      <= ena_d;
      addr_q     <= addr_d;
    end
  end
  always_comb begin
    o_dbg_process = state_q == PROCESS;
    o_dbg_delay   = state_q == DELAY;
    o_instr       = instr_q;
    o_dbg_cause   = cause_q;
    o_trig_hit    = trig_hit_q;
  end
endmodule

// File: tb/tb_serv_dbg_fetch.sv
// tb_serv_dbg_fetch: scoreboard bench for serv_dbg_fetch.
module tb_serv_dbg_fetch;
  localparam logic [31:0] EB  = 32'h00100073;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct packed {
    logic rst, wb, cnt, dret, halt, step, twen, tena;
    logic [1:0] tidx;
    logic [31:0] rdt, pc, taddr;
  } stim_t;
  logic clk = 0;
  logic i_rst, i_wb_en, i_cnt_done, i_dret, i_dbg_halt, i_dbg_step, i_trig_wen, i_trig_ena;
  logic [31:0] i_wb_rdt, i_pc, i_trig_addr;
  logic [1:0] i_trig_idx;
  logic [31:0] o_instr;
  logic o_dbg_process, o_dbg_delay;
  logic [2:0] o_dbg_cause;
  logic [1:0] o_trig_hit;
  logic [38:0] obs;
  stim_t stim_q [$];
  logic [38:0] exp_q [$];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign obs = {o_instr, o_dbg_process, o_dbg_delay, o_dbg_cause, o_trig_hit};
  serv_dbg_fetch #(.NUM_TRIG(2), .TRIG_IDX_W(2)) dut (
    .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en), .i_pc(i_pc),
    .i_cnt_done(i_cnt_done), .i_dret(i_dret), .i_dbg_halt(i_dbg_halt), .i_dbg_step(i_dbg_step),
    .i_trig_wen(i_trig_wen), .i_trig_idx(i_trig_idx), .i_trig_addr(i_trig_addr), .i_trig_ena(i_trig_ena),
    .o_instr(o_instr), .o_dbg_process(o_dbg_process), .o_dbg_delay(o_dbg_delay),
    .o_dbg_cause(o_dbg_cause), .o_trig_hit(o_trig_hit)
  );
  function automatic logic [38:0] mk(logic [31:0] ins, logic p, logic d, logic [2:0] c, logic [1:0] h);
    return {ins, p, d, c, h};
  endfunction
  function automatic stim_t s(logic wb, logic [31:0] rdt, logic [31:0] pc, logic cnt, logic dret, logic halt, logic step);
    stim_t x = '0;
    x.wb = wb; x.rdt = rdt; x.pc = pc; x.cnt = cnt; x.dret = dret; x.halt = halt; x.step = step;
    return x;
  endfunction
  function automatic stim_t sw(logic [1:0] idx, logic [31:0] addr, logic ena, logic wb, logic [31:0] rdt, logic [31:0] pc);
    stim_t x = s(wb, rdt, pc, 0, 0, 0, 0);
    x.twen = 1; x.tidx = idx; x.taddr = addr; x.tena = ena;
    return x;
  endfunction
  function automatic stim_t sr();
    stim_t x = '0;
    x.rst = 1;
    return x;
  endfunction
  task automatic apply(stim_t x);
    i_rst = x.rst; i_wb_en = x.wb; i_wb_rdt = x.rdt; i_pc = x.pc; i_cnt_done = x.cnt;
    i_dret = x.dret; i_dbg_halt = x.halt; i_dbg_step = x.step; i_trig_wen = x.twen;
    i_trig_idx = x.tidx; i_trig_addr = x.taddr; i_trig_ena = x.tena;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [38:0] e;
    stim_q.push_back(sr());                           exp_q.push_back(mk(NOP, 0, 1, 0, 0));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));         exp_q.push_back(mk(NOP, 0, 0, 0, 0));
    stim_q.push_back(s(1, 32'h00a00093, 32'h100, 0, 0, 0, 0)); exp_q.push_back(mk(32'h00a00093, 0, 0, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset[%0d] got %h exp %h", i, obs, e); end
    end
  endtask
  task automatic test_halt();
    logic [38:0] e;
    stim_q.push_back(s(1, 32'h00a00093, 32'h104, 0, 0, 1, 0)); exp_q.push_back(mk(EB, 1, 0, 3, 0));
    stim_q.push_back(s(1, 32'h00200113, 32'h108, 0, 0, 1, 0)); exp_q.push_back(mk(32'h00200113, 1, 0, 3, 0));
    stim_q.push_back(s(0, 0, 0, 1, 1, 0, 0));                  exp_q.push_back(mk(32'h00200113, 0, 1, 3, 0));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));                  exp_q.push_back(mk(32'h00200113, 0, 0, 3, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL halt[%0d] got %h exp %h", i, obs, e); end
    end
  endtask
  task automatic test_trigger();
    logic [38:0] e;
    stim_q.push_back(sw(1, 32'h80000010, 1, 0, 0, 0));              exp_q.push_back(mk(32'h00200113, 0, 0, 3, 0));
    stim_q.push_back(s(1, 32'h00300193, 32'h8000000C, 0, 0, 0, 0)); exp_q.push_back(mk(32'h00300193, 0, 0, 3, 0));
    stim_q.push_back(s(1, 32'h00400213, 32'h80000010, 0, 0, 1, 0)); exp_q.push_back(mk(EB, 1, 0, 2, 2'b10));
    stim_q.push_back(s(0, 0, 0, 1, 1, 0, 0));                       exp_q.push_back(mk(EB, 0, 1, 2, 2'b10));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));                       exp_q.push_back(mk(EB, 0, 0, 2, 2'b10));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL trigger[%0d] got %h exp %h", i, obs, e); end
    end
  endtask
  task automatic test_step();
    logic [38:0] e;
    stim_q.push_back(s(1, 32'h00500293, 32'h110, 0, 0, 0, 1)); exp_q.push_back(mk(EB, 1, 0, 4, 0));
    stim_q.push_back(s(0, 0, 0, 1, 1, 0, 1));                  exp_q.push_back(mk(EB, 0, 1, 4, 0));
    stim_q.push_back(s(1, 32'h00600313, 32'h114, 0, 0, 0, 1)); exp_q.push_back(mk(32'h00600313, 0, 1, 4, 0));
    stim_q.push_back(s(1, 32'h00700393, 32'h118, 1, 0, 0, 1)); exp_q.push_back(mk(32'h00700393, 0, 0, 4, 0));
    stim_q.push_back(s(1, 32'h00800413, 32'h11c, 0, 0, 0, 1)); exp_q.push_back(mk(EB, 1, 0, 4, 0));
    stim_q.push_back(s(0, 0, 0, 1, 1, 0, 0));                  exp_q.push_back(mk(EB, 0, 1, 4, 0));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));                  exp_q.push_back(mk(EB, 0, 0, 4, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL step[%0d] got %h exp %h", i, obs, e); end
    end
  endtask
  task automatic test_ebreak();
    logic [38:0] e;
    stim_q.push_back(s(1, EB, 32'h200, 0, 0, 0, 0));           exp_q.push_back(mk(EB, 1, 0, 1, 0));
    stim_q.push_back(s(1, EB, 32'h204, 0, 0, 0, 0));           exp_q.push_back(mk(EB, 1, 0, 1, 0));
    stim_q.push_back(s(1, 32'h00b00593, 32'h208, 0, 0, 0, 0)); exp_q.push_back(mk(32'h00b00593, 1, 0, 1, 0));
    stim_q.push_back(s(0, 0, 0, 1, 1, 0, 0));                  exp_q.push_back(mk(32'h00b00593, 0, 1, 1, 0));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));                  exp_q.push_back(mk(32'h00b00593, 0, 0, 1, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL ebreak[%0d] got %h exp %h", i, obs, e); end
    end
  endtask
  task automatic test_corners();
    logic [38:0] e;
    stim_q.push_back(sw(0, 32'h300, 1, 1, 32'h00900493, 32'h300));  exp_q.push_back(mk(32'h00900493, 0, 0, 1, 0));
    stim_q.push_back(s(1, 32'h00c00613, 32'h300, 0, 0, 0, 0));      exp_q.push_back(mk(EB, 1, 0, 2, 2'b01));
    stim_q.push_back(s(0, 0, 0, 1, 1, 0, 0));                       exp_q.push_back(mk(EB, 0, 1, 2, 2'b01));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));                       exp_q.push_back(mk(EB, 0, 0, 2, 2'b01));
    stim_q.push_back(sw(3, 32'h400, 1, 0, 0, 0));                   exp_q.push_back(mk(EB, 0, 0, 2, 2'b01));
    stim_q.push_back(s(1, 32'h00d00693, 32'h400, 0, 0, 0, 0));      exp_q.push_back(mk(32'h00d00693, 0, 0, 2, 2'b01));
    stim_q.push_back(s(1, 32'h00e00713, 32'h404, 1, 1, 0, 0));      exp_q.push_back(mk(32'h00e00713, 0, 0, 2, 2'b01));
    stim_q.push_back(s(1, 32'h00f00793, 32'h408, 0, 0, 1, 0));      exp_q.push_back(mk(EB, 1, 0, 3, 0));
    stim_q.push_back(sr());                                         exp_q.push_back(mk(NOP, 0, 1, 0, 0));
    stim_q.push_back(s(0, 0, 0, 1, 0, 0, 0));                       exp_q.push_back(mk(NOP, 0, 0, 0, 0));
    stim_q.push_back(s(1, 32'h01000813, 32'h80000010, 0, 0, 0, 0)); exp_q.push_back(mk(32'h01000813, 0, 0, 0, 0));
    stim_q.push_back(s(1, 32'h01100893, 32'h300, 0, 0, 0, 0));      exp_q.push_back(mk(32'h01100893, 0, 0, 0, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL corners[%0d] got %h exp %h", i, obs, e); end
    end
  endtask
  initial begin
    i_rst = 1; i_wb_en = 0; i_wb_rdt = 0; i_pc = 0; i_cnt_done = 0; i_dret = 0;
    i_dbg_halt = 0; i_dbg_step = 0; i_trig_wen = 0; i_trig_idx = 0; i_trig_addr = 0; i_trig_ena = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_halt();
    test_trigger();
    test_step();
    test_ebreak();
    test_corners();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serv_dbg_fetch.md
# serv_dbg_fetch

Debug-aware instruction latch and entry controller for the bit-serial SERV core. Captures each fetched instruction word and, on debug entry, substitutes `ebreak`. It tracks the RUN / PROCESS / DELAY debug state and reports the entry cause. It adds a parametrised bank of PC-match hardware breakpoint triggers. It sits between the instruction bus and the combinational decoder, so every downstream decode field derives from `o_instr`.

## Interface
- `NUM_TRIG`, default 2: number of PC-match triggers, legal range 1..4.
- `TRIG_IDX_W`, default 2: width of the trigger index; must satisfy 2^TRIG_IDX_W ≥ NUM_TRIG.
- `clk` input 1: clock.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_wb_rdt` input 32: fetched instruction word.
- `i_wb_en` input 1: fetch strobe; capture `i_wb_rdt` this cycle.
- `i_pc` input 32: PC of the instruction on `i_wb_rdt`, valid while `i_wb_en` is high.
- `i_cnt_done` input 1: current instruction completes this cycle.
- `i_dret` input 1: decoded instruction in `o_instr` is `dret`.
- `i_dbg_halt` input 1: external halt request, level.
- `i_dbg_step` input 1: single-step mode, level.
- `i_trig_wen` input 1: trigger write strobe.
- `i_trig_idx` input TRIG_IDX_W: trigger index to write.
- `i_trig_addr` input 32: trigger match address.
- `i_trig_ena` input 1: trigger enable value to write.
- `o_instr` output 32: latched instruction, possibly substituted.
- `o_dbg_process` output 1: core is in debug mode (state PROCESS).
- `o_dbg_delay` output 1: no-entry window (state DELAY).
- `o_dbg_cause` output 3: dcsr.cause of the last entry. 1 = ebreak, 2 = trigger, 3 = haltreq, 4 = step.
- `o_trig_hit` output NUM_TRIG: triggers that matched at the last entry.

## Operation
- States are RUN, PROCESS and DELAY.
- One-hot outputs follow the state: `o_dbg_process` = (PROCESS), `o_dbg_delay` = (DELAY).
- **Trigger bank**
  - Each entry holds `addr[31:0]` and `ena`.
  - When `i_trig_wen` is high, entry `i_trig_idx` loads `i_trig_addr` and `i_trig_ena`.
  - If `i_trig_idx` ≥ NUM_TRIG, the write is ignored.
  - `hit[k] = ena[k] & (addr[k] == i_pc)`.
- **Injection**
  - Injection happens only in RUN, on a cycle with `i_wb_en` high.
  - Request `req = |hit | i_dbg_halt | i_dbg_step`.
  - If `req` is set, `o_instr` loads 0x00100073 (`ebreak`). Otherwise it loads `i_wb_rdt`.
- **Cause priority** (evaluated on that same cycle):
  - trigger (2) > haltreq (3) > step (4) > fetched `i_wb_rdt` == 0x00100073 (1).
  - `o_trig_hit` loads `hit` when the cause is 2, and zero otherwise.
- **Transitions**
  - RUN → PROCESS: on an injection, or on a genuine `ebreak` fetch, on an `i_wb_en` cycle. `o_dbg_cause` updates in the same edge.
  - PROCESS: instructions pass through unmodified. A fetched `ebreak` does not change cause or state.
  - PROCESS → DELAY: when `i_dret & i_cnt_done`.
  - DELAY: no injection and no cause update, so exactly one instruction after `dret` executes. Single-step relies on this.
  - DELAY → RUN: on `i_cnt_done`.
- **Ignored events**
  - `i_dret` outside PROCESS.
  - `i_cnt_done` in RUN.
  - `i_wb_en` low: `o_instr` holds.
- **Simultaneous events**
  - A trigger write in the same cycle as a fetch: the comparison uses the pre-write contents.
  - `i_wb_en` in the same cycle as a DELAY → RUN transition: evaluated under DELAY, so no injection.
- **Reset mid-operation**
  - Reset aborts any state.
  - All trigger entries clear (`ena` = 0, `addr` = 0).

## Timing
- All outputs are registered and update on the clock edge after the qualifying input cycle.
- Injection-to-`o_instr` latency is 1 cycle, identical to a normal fetch.
- Reset values:
  - `o_instr` = 0x00000013 (NOP).
  - State DELAY: `o_dbg_delay` = 1, `o_dbg_process` = 0.
  - `o_dbg_cause` = 0, `o_trig_hit` = 0.
- After reset, the first `i_cnt_done` moves the block to RUN. Requests are honoured from the next fetch onward.
- The trigger compare is purely combinational into the `o_instr` register. A write takes effect on the fetch one cycle after `i_trig_wen`.

## Test plan
- **Reset:** after reset, `o_instr` = 0x00000013, `o_dbg_delay` = 1, cause 0. Pulse `i_cnt_done` → `o_dbg_delay` = 0. Fetch 0x00a00093 → `o_instr` = 0x00a00093, state stays RUN.
- **Halt:** in RUN, hold `i_dbg_halt` and fetch 0x00a00093 → `o_instr` = 0x00100073, `o_dbg_process` = 1, cause 3. Fetch during PROCESS → unmodified. `i_dret` + `i_cnt_done` → DELAY. Next `i_cnt_done` → RUN.
- **Trigger:** write trigger 1 with addr 0x80000010, ena 1. Fetch at PC 0x8000000C → normal. Fetch at PC 0x80000010 with `i_dbg_halt` also high → `ebreak` injected, cause 2, `o_trig_hit` = 2'b10.
- **Step:** hold `i_dbg_step`. After `dret`, exactly one fetched instruction passes unmodified during DELAY. The following fetch is injected with cause 4.
- **Genuine ebreak:** in RUN, fetch 0x00100073 with no requests → PROCESS, cause 1, `o_trig_hit` = 0. Fetch 0x00100073 again in PROCESS → cause stays 1.
- **Corner cases:**
  - Trigger write and matching fetch in the same cycle → no hit.
  - Write to index 3 with NUM_TRIG = 2 → no effect.
  - `i_rst` asserted in PROCESS → DELAY, cause 0, triggers cleared.
